// File: rtl/mono_inj_seq.sv
// Injection/gate sequencer for MONOPIX scans: Gray reset, TDC gate window, injection pulse, FIFO pause.
// Optional macro INJ_SEQ_EXT_TRIG_EN adds EXT_TRIG gating of every injection cycle.
module mono_inj_seq #(
   parameter int CNT_WIDTH = 16,
   parameter int DLY_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic                 ABORT,
   input  logic [CNT_WIDTH-1:0] REPEAT,
   input  logic [3:0]           GRAY_RST_LEN,
   input  logic [DLY_WIDTH-1:0] INJ_DELAY,
   input  logic [DLY_WIDTH-1:0] INJ_WIDTH,
   input  logic [CNT_WIDTH-1:0] GATE_WIDTH,
   input  logic [DLY_WIDTH-1:0] HOLD_OFF,
   input  logic                 FIFO_NEAR_FULL,
`ifdef INJ_SEQ_EXT_TRIG_EN
   input  logic                 EXT_TRIG,
`endif
   output logic                 RST_GRAY,
   output logic                 GATE,
   output logic                 INJ,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [CNT_WIDTH-1:0] CYCLE_CNT
);

   localparam int CW = (CNT_WIDTH > DLY_WIDTH) ? CNT_WIDTH : DLY_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRST,
      S_DELAY,
      S_INJ,
      S_TAIL,
      S_PAUSE
   } state_t;

   state_t               state, state_nxt, first_ph;
   logic [CW-1:0]        cnt, load;
   logic [CNT_WIDTH-1:0] rep_q, gw_q;
   logic [3:0]           grl_q, grl_s;
   logic [DLY_WIDTH-1:0] dly_q, wid_q, ho_q;
   logic [DLY_WIDTH-1:0] dly_s, wid_s, ho_s;
   logic                 idle, start_ok, done_nxt, cyc_end, cyc_inc, trig_ok;

   assign idle = (state == S_IDLE);

`ifdef INJ_SEQ_EXT_TRIG_EN
   logic [2:0] trig_sync;
   logic       trig_seen;
   logic       trig_edge;

   assign trig_edge = trig_sync[1] && !trig_sync[2];

   // Edges only count while waiting in PAUSE; one edge releases one cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         trig_sync <= '0;
         trig_seen <= 1'b0;
      end else begin
         trig_sync <= {trig_sync[1:0], EXT_TRIG};
         if (state != S_PAUSE)
            trig_seen <= 1'b0;
         else if (trig_edge)
            trig_seen <= 1'b1;
      end
   end

   assign trig_ok = trig_seen || trig_edge;
`else
   assign trig_ok = 1'b1;
`endif

   // In IDLE the live inputs decide the first phase, since they are latched on that same edge.
   always_comb begin
      grl_s     = idle ? GRAY_RST_LEN : grl_q;
      dly_s     = idle ? INJ_DELAY    : dly_q;
      wid_s     = idle ? INJ_WIDTH    : wid_q;
      ho_s      = idle ? HOLD_OFF     : ho_q;
      first_ph  = (grl_s != '0) ? S_GRST : ((dly_s != '0) ? S_DELAY : S_INJ);
      state_nxt = state;
      start_ok  = 1'b0;
      done_nxt  = 1'b0;
      cyc_end   = 1'b0;
      cyc_inc   = 1'b0;

      case (state)
         S_IDLE: begin
            if (START) begin
               if (REPEAT == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  start_ok = 1'b1;
`ifdef INJ_SEQ_EXT_TRIG_EN
                  state_nxt = S_PAUSE;
`else
                  state_nxt = first_ph;
`endif
               end
            end
         end
         S_GRST:  if (cnt == '0) state_nxt = (dly_s != '0) ? S_DELAY : S_INJ;
         S_DELAY: if (cnt == '0) state_nxt = S_INJ;
         S_INJ: begin
            if (cnt == '0) begin
               if (gw_q != '0) state_nxt = S_TAIL;
               else            cyc_end   = 1'b1;
            end
         end
         S_TAIL:  if (cnt == '0) cyc_end = 1'b1;
         S_PAUSE: if (cnt == '0 && !FIFO_NEAR_FULL && trig_ok) state_nxt = first_ph;
         default: state_nxt = S_IDLE;
      endcase

      if (cyc_end) begin
         cyc_inc = 1'b1;
         if (CYCLE_CNT + 1'b1 == rep_q) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
         end else begin
            state_nxt = S_PAUSE;
         end
      end

      if (ABORT) begin
         state_nxt = S_IDLE;
         start_ok  = 1'b0;
         done_nxt  = 1'b0;
         cyc_inc   = 1'b0;
      end

      // Counter holds "cycles left after this one"; PAUSE lasts at least one cycle so the FIFO flag is seen.
      case (state_nxt)
         S_GRST:  load = CW'(grl_s) - CW'(1);
         S_DELAY: load = CW'(dly_s) - CW'(1);
         S_INJ:   load = (wid_s == '0) ? '0 : CW'(wid_s) - CW'(1);
         S_TAIL:  load = CW'(gw_q) - CW'(1);
         S_PAUSE: load = (ho_s == '0) ? '0 : CW'(ho_s) - CW'(1);
         default: load = '0;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rep_q     <= '0;
         gw_q      <= '0;
         grl_q     <= '0;
         dly_q     <= '0;
         wid_q     <= '0;
         ho_q      <= '0;
         CYCLE_CNT <= '0;
         RST_GRAY  <= 1'b0;
         GATE      <= 1'b0;
         INJ       <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            cnt <= load;
         else if (cnt != '0)
            cnt <= cnt - 1'b1;

         if (start_ok) begin
            rep_q <= REPEAT;
            gw_q  <= GATE_WIDTH;
            grl_q <= GRAY_RST_LEN;
            dly_q <= INJ_DELAY;
            wid_q <= INJ_WIDTH;
            ho_q  <= HOLD_OFF;
         end

         if (start_ok)
            CYCLE_CNT <= '0;
         else if (cyc_inc)
            CYCLE_CNT <= CYCLE_CNT + 1'b1;

         RST_GRAY <= (state_nxt == S_GRST);
         GATE     <= (state_nxt == S_DELAY) || (state_nxt == S_INJ) || (state_nxt == S_TAIL);
         INJ      <= (state_nxt == S_INJ);
         BUSY     <= (state_nxt != S_IDLE);
         DONE     <= done_nxt;
      end
   end

endmodule

// File: tb/tb_mono_inj_seq.sv
// Self-checking bench for mono_inj_seq: per-cycle waveform reference built from the phase rules.
module tb_mono_inj_seq;

   localparam int CW = 16;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst, start, abort, fifo_near_full;
   logic [CW-1:0] repeat_n, gate_width;
   logic [3:0]    gray_rst_len;
   logic [DW-1:0] inj_delay, inj_width, hold_off;
   logic          rst_gray, gate, inj, busy, done;
   logic [CW-1:0] cycle_cnt;

   int checks  = 0;
   int errors  = 0;
   int exp_cyc = 0;
   logic [4:0] exp_q[$];

   mono_inj_seq #(.CNT_WIDTH(CW), .DLY_WIDTH(DW)) dut (
      .CLK(clk), .RST(rst), .START(start), .ABORT(abort),
      .REPEAT(repeat_n), .GRAY_RST_LEN(gray_rst_len), .INJ_DELAY(inj_delay),
      .INJ_WIDTH(inj_width), .GATE_WIDTH(gate_width), .HOLD_OFF(hold_off),
      .FIFO_NEAR_FULL(fifo_near_full),
      .RST_GRAY(rst_gray), .GATE(gate), .INJ(inj), .BUSY(busy), .DONE(done),
      .CYCLE_CNT(cycle_cnt)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] outs();
      return {rst_gray, gate, inj, busy, done};
   endfunction

   task automatic set_cfg(input int rep, grl, dly, wid, gw, ho);
      repeat_n     = CW'(rep);
      gray_rst_len = 4'(grl);
      inj_delay    = DW'(dly);
      inj_width    = DW'(wid);
      gate_width   = CW'(gw);
      hold_off     = DW'(ho);
   endtask

   // Reference waveform {RST_GRAY,GATE,INJ,BUSY,DONE} for the edges after START is sampled.
   task automatic build_run(input int rep, grl, dly, wid, gw, ho);
      exp_q.delete();
      for (int c = 0; c < rep; c++) begin
         repeat (grl) exp_q.push_back(5'b10010);
         repeat (dly) exp_q.push_back(5'b01010);
         repeat ((wid == 0) ? 1 : wid) exp_q.push_back(5'b01110);
         repeat (gw) exp_q.push_back(5'b01010);
         if (c != rep - 1) repeat ((ho == 0) ? 1 : ho) exp_q.push_back(5'b00010);
      end
      exp_q.push_back(5'b00001);
      exp_q.push_back(5'b00000);
   endtask

   task automatic run_model(input string tag, input int rep, grl, dly, wid, gw, ho, input bit noise);
      logic [4:0] e;
      build_run(rep, grl, dly, wid, gw, ho);
      set_cfg(rep, grl, dly, wid, gw, ho);
      start = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
         step();
         start = 1'b0;
         e = exp_q[i];
         chk($sformatf("%s_e%0d", tag, i + 1), 32'(outs()), 32'(e));
         if (noise) begin
            start          = e[1] ? 1'($urandom_range(0, 1)) : 1'b0;
            fifo_near_full = (e != 5'b00010) ? 1'($urandom_range(0, 1)) : 1'b0;
            set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
         end
      end
      start          = 1'b0;
      fifo_near_full = 1'b0;
      if (rep != 0) exp_cyc = rep;
      chk({tag, "_cnt"}, 32'(cycle_cnt), 32'(exp_cyc));
   endtask

   initial begin
      bit found;
      int windows;
      logic gate_prev;

      rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_near_full = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0);
      repeat (3) step();
      chk("reset_outs", 32'(outs()), 32'd0);
      chk("reset_cnt", 32'(cycle_cnt), 32'd0);
      rst = 1'b0;
      step();
      chk("idle_outs", 32'(outs()), 32'd0);

      run_model("basic", 1, 2, 3, 2, 4, 0, 1'b0);
      run_model("rep0", 0, 2, 3, 2, 4, 0, 1'b0);
      run_model("w0_g0", 2, 0, 2, 0, 1, 0, 1'b0);
      run_model("d0_t0", 2, 1, 0, 1, 0, 3, 1'b0);

      // backpressure during the first PAUSE
      set_cfg(3, 1, 1, 1, 1, 5);
      start = 1'b1;
      step();
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (busy && !gate && !rst_gray) found = 1'b1;
         else step();
      end
      chk("bp_pause_seen", 32'(found), 32'd1);
      fifo_near_full = 1'b1;
      repeat (20) begin
         step();
         chk("bp_hold", 32'({rst_gray, gate, busy}), 32'(3'b001));
      end
      fifo_near_full = 1'b0;
      step();
      chk("bp_resume", 32'(rst_gray), 32'd1);
      windows   = 1;
      gate_prev = gate;
      found     = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step();
         if (gate && !gate_prev) windows++;
         gate_prev = gate;
         if (done) found = 1'b1;
      end
      chk("bp_done", 32'(found), 32'd1);
      chk("bp_windows", 32'(windows), 32'd3);
      chk("bp_cnt", 32'(cycle_cnt), 32'd3);
      exp_cyc = 3;
      step();

      // abort during the INJ phase of the second cycle
      set_cfg(4, 1, 2, 3, 2, 2);
      start = 1'b1;
      step();
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (inj && cycle_cnt == CW'(1)) found = 1'b1;
         else step();
      end
      chk("ab_inj2_seen", 32'(found), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_outs", 32'(outs()), 32'd0);
      chk("ab_cnt", 32'(cycle_cnt), 32'd1);
      exp_cyc = 1;
      repeat (4) begin
         step();
         chk("ab_quiet", 32'({busy, done}), 32'd0);
      end

      // START together with ABORT in IDLE
      set_cfg(2, 1, 1, 1, 1, 1);
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_outs1", 32'(outs()), 32'd0);
      step();
      chk("sa_outs2", 32'(outs()), 32'd0);
      chk("sa_cnt", 32'(cycle_cnt), 32'(exp_cyc));

      // randomized runs with mid-run config changes, START while busy and FIFO noise
      for (int r = 0; r < 25; r++) begin
         run_model($sformatf("rnd%0d", r), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 4)), 1'b1);
      end

      // asynchronous reset inside a GATE window
      set_cfg(2, 0, 3, 2, 3, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("rg_gate_up", 32'(gate), 32'd1);
      step();
      #2 rst = 1'b1;
      #1;
      chk("rg_async_outs", 32'(outs()), 32'd0);
      chk("rg_async_cnt", 32'(cycle_cnt), 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("rg_after", 32'(outs()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mono_inj_seq.md
# mono_inj_seq

Injection/gate sequencer for MONOPIX scans in the 40 MHz domain. Each accepted start runs a programmed number of injection cycles. Every cycle does four things in order:
- resets the Gray-coded timestamp (RST_GRAY),
- opens the TDC gate window (GATE),
- fires a charge-injection pulse (INJ) inside that window,
- pauses while the readout FIFO is near full.

It replaces the loose pairing of the injection and TDC-gate pulse generators with one deterministic controller. Its outputs feed the RST_GRAY pad register, tdc_s3 EXT_EN and the INJECTION pin.

## Interface
Parameters:
- CNT_WIDTH, 16, width of REPEAT, GATE_WIDTH and CYCLE_CNT
- DLY_WIDTH, 8, width of INJ_DELAY, INJ_WIDTH and HOLD_OFF

Ports:
- CLK  in  1  sequencer clock (CLK40)
- RST  in  1  asynchronous, active-high reset
- START  in  1  single-cycle start request
- ABORT  in  1  single-cycle abort request
- REPEAT  in  CNT_WIDTH  number of injection cycles
- GRAY_RST_LEN  in  4  RST_GRAY length in cycles; 0 = skip the Gray reset
- INJ_DELAY  in  DLY_WIDTH  cycles from GATE rise to INJ rise
- INJ_WIDTH  in  DLY_WIDTH  INJ high time; 0 is treated as 1
- GATE_WIDTH  in  CNT_WIDTH  cycles GATE stays high after INJ falls
- HOLD_OFF  in  DLY_WIDTH  minimum idle cycles between injection cycles
- FIFO_NEAR_FULL  in  1  backpressure from sram_fifo
- RST_GRAY  out  1  Gray-counter reset request
- GATE  out  1  TDC enable window
- INJ  out  1  injection pulse
- BUSY  out  1  sequence running
- DONE  out  1  one-cycle pulse when the last cycle completes
- CYCLE_CNT  out  CNT_WIDTH  completed injection cycles

## Operation
- States: IDLE, GRST, DELAY, INJ, TAIL, PAUSE. A single down-counter is reloaded on every state entry.
- All configuration inputs are latched when START is accepted. Changing them during a run has no effect.
- Transitions:
  - IDLE: START with REPEAT≠0 → GRST (or → DELAY if GRAY_RST_LEN=0); CYCLE_CNT cleared. START with REPEAT=0 → DONE pulse only, stay IDLE.
  - GRST: RST_GRAY=1 for GRAY_RST_LEN cycles → DELAY.
  - DELAY: GATE=1 for INJ_DELAY cycles → INJ. With INJ_DELAY=0, INJ is entered directly.
  - INJ: GATE=1, INJ=1 for max(INJ_WIDTH,1) cycles → TAIL.
  - TAIL: GATE=1 for GATE_WIDTH cycles. CYCLE_CNT increments on exit. If CYCLE_CNT+1 = REPEAT → IDLE with DONE; otherwise → PAUSE.
  - PAUSE: all outputs low. Exit requires both HOLD_OFF cycles elapsed and FIFO_NEAR_FULL=0 → GRST (or DELAY).
- ABORT has priority over every transition: next state IDLE, all pulse outputs low, no DONE, CYCLE_CNT holds.
- START while BUSY is ignored. START together with ABORT in IDLE: ABORT wins and START is dropped.
- CYCLE_CNT never wraps, since REPEAT ≤ 2^CNT_WIDTH−1. It holds its final value until the next START.

## Timing
- All outputs are registered and decoded from the next state. An output is valid in the first cycle of the state that drives it.
- Reset values: every output 0, CYCLE_CNT 0, state IDLE. Reset asserted mid-sequence kills INJ and GATE immediately (asynchronous clear).
- START sampled at edge 0 → BUSY and the first phase output rise at edge 1.
- GATE is high for INJ_DELAY + max(INJ_WIDTH,1) + GATE_WIDTH contiguous cycles per injection cycle.
- INJ is always strictly inside GATE when INJ_DELAY ≥ 1.
- DONE is asserted in the same cycle BUSY falls.
- FIFO_NEAR_FULL is sampled only in PAUSE. It never truncates a running GATE/INJ window.

## Configuration
- INJ_SEQ_EXT_TRIG_EN: when defined, adds input EXT_TRIG (1 bit, asynchronous).
  - EXT_TRIG passes through a 2-flop synchronizer plus rising-edge detect.
  - Every injection cycle, including the first after START, then waits in PAUSE for one detected edge in addition to the HOLD_OFF and FIFO conditions.
- When undefined, the port is absent and the first cycle starts directly from IDLE.

## Test plan
- Basic run: REPEAT=1, GRAY_RST_LEN=2, INJ_DELAY=3, INJ_WIDTH=2, GATE_WIDTH=4, START at edge 0. Required: RST_GRAY high edges 1–2; GATE high edges 3–11; INJ high edges 6–7; DONE and BUSY-fall at edge 12; CYCLE_CNT=1.
- Repeat with backpressure: REPEAT=3, HOLD_OFF=5, FIFO_NEAR_FULL held high for 20 cycles during the first PAUSE. Required: the second GRST starts exactly one cycle after FIFO_NEAR_FULL falls; three GATE windows total; CYCLE_CNT=3.
- Abort: ABORT asserted during the INJ phase of cycle 2 of REPEAT=4. Required: INJ, GATE and BUSY low the next cycle; no DONE; CYCLE_CNT=1.
- Edge configurations: REPEAT=0 → DONE pulse only, no BUSY. INJ_WIDTH=0 and GRAY_RST_LEN=0 → no RST_GRAY and a 1-cycle INJ. START while BUSY → ignored. START+ABORT together in IDLE → nothing starts.
- Reset and latching: change INJ_DELAY mid-run → no effect on the current run. Assert RST during GATE → all outputs 0 asynchronously.
- With INJ_SEQ_EXT_TRIG_EN defined: each cycle starts only after an EXT_TRIG rising edge. Sync latency is 2–3 cycles.
